// File: rtl/pipeline_fence_gate.sv
// Operand gate in front of the float arithmetic pipeline.
// A 2-entry skid buffer forwards operands with registered outputs. A fence
// stops intake, drains the buffer, waits for the in-flight tracker to report
// a quiet pipeline for GUARD_CYCLES cycles, then pulses fence_ack. An optional
// timeout forces completion and leaves any buffered operands in place.
module pipeline_fence_gate #(
    parameter int DATA_WIDTH     = 64,
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  sig_incoming,
    input  logic                  pipe_busy,
    input  logic                  fence_req,
    output logic                  fence_ack,
    output logic                  fence_timeout,
    output logic                  fence_active
);

    typedef enum logic [2:0] {PASS, BLOCK, SETTLE, DONE, ACKWAIT} fenceState_t;

    localparam logic [16:0] TMO_LIMIT   = 17'(TIMEOUT_CYCLES);
    localparam logic [3:0]  GUARD_LIMIT = 4'(GUARD_CYCLES);

    fenceState_t           state;
    logic [DATA_WIDTH-1:0] skidData;
    logic                  skidValid;
    logic                  push;
    logic                  pop;
    logic [1:0]            entries;
    logic [1:0]            entriesNext;
    logic                  passNext;
    logic [3:0]            guardCnt;
    logic [15:0]           tmoCnt;
    logic                  tmoHit;
    logic                  guardHit;
    logic                  bufIdle;

    // The head register drives m_axis directly; skid only fills when the head is stalled.
    assign push         = s_axis_tvalid & s_axis_tready;
    assign pop          = m_axis_tvalid & m_axis_tready;
    assign sig_incoming = pop;
    assign entries      = 2'(m_axis_tvalid) + 2'(skidValid);
    assign entriesNext  = entries + 2'(push) - 2'(pop);

    // Intake is allowed only while the FSM will be in PASS next cycle.
    assign passNext = !fence_req && (state == PASS || state == ACKWAIT);

    // Counter compares are made against the value it will hold after this cycle.
    assign tmoHit   = (TIMEOUT_CYCLES != 0) && (({1'b0, tmoCnt} + 17'd1) >= TMO_LIMIT);
    assign guardHit = (guardCnt + 4'd1) == GUARD_LIMIT;
    assign bufIdle  = (entries == 2'd0) && !sig_incoming;

    // Skid buffer storage and registered upstream ready.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            skidValid     <= 1'b0;
            skidData      <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= (entriesNext < 2'd2) && passNext;
            if (pop) begin
                if (skidValid) begin
                    // Skid moves to head; a push can only arrive when skid was empty,
                    // so refilling skid here keeps order.
                    m_axis_tdata <= skidData;
                    skidValid    <= push;
                    if (push) skidData <= s_axis_tdata;
                end else begin
                    m_axis_tvalid <= push;
                    if (push) m_axis_tdata <= s_axis_tdata;
                end
            end else if (push) begin
                if (!m_axis_tvalid) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= s_axis_tdata;
                end else begin
                    skidValid <= 1'b1;
                    skidData  <= s_axis_tdata;
                end
            end
        end
    end

    // Fence FSM with guard/timeout counters and registered status outputs.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state         <= PASS;
            guardCnt      <= '0;
            tmoCnt        <= '0;
            fence_ack     <= 1'b0;
            fence_timeout <= 1'b0;
            fence_active  <= 1'b0;
        end else begin
            fence_ack     <= 1'b0;
            fence_timeout <= 1'b0;
            // Saturating so a long stall never wraps back under the limit.
            if ((state == BLOCK || state == SETTLE) && tmoCnt != 16'hFFFF)
                tmoCnt <= tmoCnt + 16'd1;
            case (state)
                PASS: begin
                    if (fence_req) begin
                        state        <= BLOCK;
                        fence_active <= 1'b1;
                        tmoCnt       <= '0;
                    end
                end
                BLOCK: begin
                    if (tmoHit) begin
                        state         <= DONE;
                        fence_ack     <= 1'b1;
                        fence_timeout <= 1'b1;
                    end else if (bufIdle) begin
                        state    <= SETTLE;
                        guardCnt <= '0;
                    end
                end
                SETTLE: begin
                    if (tmoHit) begin
                        state         <= DONE;
                        fence_ack     <= 1'b1;
                        fence_timeout <= 1'b1;
                    end else if (pipe_busy) begin
                        // Tracker saw activity: the quiet window starts over.
                        guardCnt <= '0;
                    end else if (guardHit) begin
                        state     <= DONE;
                        fence_ack <= 1'b1;
                    end else begin
                        guardCnt <= guardCnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= ACKWAIT;
                end
                ACKWAIT: begin
                    // Requester must drop fence_req before another fence can start.
                    if (!fence_req) begin
                        state        <= PASS;
                        fence_active <= 1'b0;
                    end
                end
                default: begin
                    state        <= PASS;
                    fence_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_fence_gate.sv
// Bench for pipeline_fence_gate: the buffer is modelled as a 2-deep queue and
// the fence as a few flags advanced from the request/drain/quiet rules; DUT
// outputs are compared against it every cycle, plus directed timing checks.
module tb_pipeline_fence_gate;

    localparam int DW    = 64;
    localparam int GUARD = 2;
    localparam int TMO   = 20;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          sValid;
    logic          sReady;
    logic [DW-1:0] sData;
    logic          mValid;
    logic          mReady;
    logic [DW-1:0] mData;
    logic          incoming;
    logic          pipeBusy;
    logic          fenceReq;
    logic          fenceAck;
    logic          fenceTimeout;
    logic          fenceActive;

    pipeline_fence_gate #(
        .DATA_WIDTH(DW),
        .GUARD_CYCLES(GUARD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk(aclk),
        .resetn(resetn),
        .s_axis_tvalid(sValid),
        .s_axis_tready(sReady),
        .s_axis_tdata(sData),
        .m_axis_tvalid(mValid),
        .m_axis_tready(mReady),
        .m_axis_tdata(mData),
        .sig_incoming(incoming),
        .pipe_busy(pipeBusy),
        .fence_req(fenceReq),
        .fence_ack(fenceAck),
        .fence_timeout(fenceTimeout),
        .fence_active(fenceActive)
    );

    // 100 MHz clock.
    always #5 aclk = ~aclk;

    // Reference model state.
    logic [DW-1:0] q[$];
    int            lat[$];
    bit            mRst, mFence, mAck, mForced, mWait, mDrained;
    int            mAge, mQuiet;
    bit            autoBusy;

    // Bookkeeping.
    int nChecks, nPass, cyc, nIncSeen, ackCount, lastAckCyc, busyFallCyc, activeRiseCyc;
    bit lastPush, lastAckTmo, prevBusy, prevActive;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock: compare against the model, then advance the model across the edge.
    task automatic cycle();
        bit idle, expRdy, expMv, push, pop;
        #1;
        idle   = !mFence && !mAck && !mWait;
        expRdy = !mRst && idle && (q.size() < 2);
        expMv  = q.size() > 0;
        check("s_tready", 64'(sReady), 64'(expRdy));
        check("m_tvalid", 64'(mValid), 64'(expMv));
        if (expMv) check("m_tdata", mData, q[0]);
        check("incoming", 64'(incoming), 64'(expMv && mReady));
        check("fence_ack", 64'(fenceAck), 64'(mAck));
        check("fence_timeout", 64'(fenceTimeout), 64'(mAck && mForced));
        check("fence_active", 64'(fenceActive), 64'(!idle));
        if (incoming) nIncSeen++;
        if (fenceAck) begin
            ackCount++;
            lastAckCyc = cyc;
            lastAckTmo = fenceTimeout;
        end
        if (fenceActive && !prevActive) activeRiseCyc = cyc;
        prevActive = fenceActive;
        if (prevBusy && !pipeBusy) busyFallCyc = cyc;
        prevBusy = pipeBusy;
        push = sValid && expRdy;
        pop  = expMv && mReady;
        lastPush = push;
        @(posedge aclk);
        if (!resetn) begin
            q.delete();
            lat.delete();
            mRst = 1; mFence = 0; mAck = 0; mForced = 0; mWait = 0;
        end else begin
            mRst = 0;
            if (mAck) begin
                mAck = 0; mForced = 0; mWait = 1;
            end else if (mWait) begin
                if (!fenceReq) mWait = 0;
            end else if (mFence) begin
                mAge++;
                if (TMO != 0 && mAge >= TMO) begin
                    mFence = 0; mAck = 1; mForced = 1;
                end else if (!mDrained) begin
                    if (q.size() == 0) begin mDrained = 1; mQuiet = 0; end
                end else begin
                    if (pipeBusy) mQuiet = 0;
                    else mQuiet++;
                    if (mQuiet >= GUARD) begin mFence = 0; mAck = 1; end
                end
            end else if (fenceReq) begin
                mFence = 1; mAge = 0; mDrained = 0; mQuiet = 0;
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back(sData);
            // Tracker model: each operand entering the pipe keeps it busy for 5 cycles.
            for (int i = lat.size() - 1; i >= 0; i--) begin
                lat[i] = lat[i] - 1;
                if (lat[i] <= 0) lat.delete(i);
            end
            if (pop && autoBusy) lat.push_back(5);
        end
        cyc++;
        @(negedge aclk);
        if (autoBusy) pipeBusy = (lat.size() > 0);
    endtask

    task automatic waitAck(input string tag, input int budget);
        int start;
        int n;
        start = ackCount;
        n = 0;
        while (ackCount == start && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 64'(ackCount != start), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 30000", cyc);
        $fatal(1);
    end

    initial begin
        int idx, n, base, ackBefore;
        bit busyPat[4];
        busyPat = '{1'b0, 1'b1, 1'b0, 1'b0};
        resetn = 0; sValid = 0; sData = '0; mReady = 0; pipeBusy = 0; fenceReq = 0;
        autoBusy = 0; mRst = 1; mFence = 0; mAck = 0; mForced = 0; mWait = 0; mDrained = 0;
        mAge = 0; mQuiet = 0; nChecks = 0; nPass = 0; cyc = 0; nIncSeen = 0; ackCount = 0;
        lastAckCyc = 0; busyFallCyc = 0; activeRiseCyc = 0; lastPush = 0; lastAckTmo = 0;
        prevBusy = 0; prevActive = 0;
        @(posedge aclk);
        @(negedge aclk);

        // Reset state, then ready rises after the first edge out of reset.
        cycle();
        cycle();
        resetn = 1;
        cycle();
        check("ready_after_reset", 64'(sReady), 64'd1);

        // 100 indexed beats with a stalling consumer.
        idx = 0; n = 0; base = nIncSeen;
        while ((idx < 100 || q.size() > 0) && n < 3000) begin
            sValid = (idx < 100) && ($urandom_range(0, 9) != 0);
            sData  = DW'(idx);
            mReady = ($urandom_range(0, 9) >= 3);
            cycle();
            if (lastPush) idx++;
            n++;
        end
        check("stream_all_sent", 64'(idx), 64'd100);
        check("stream_pulses", 64'(nIncSeen - base), 64'd100);
        sValid = 0;

        // Full buffer, fence, drain, guard window after the tracker goes quiet.
        mReady = 0; sValid = 1; sData = 64'hA; cycle();
        sData = 64'hB; cycle();
        fenceReq = 1; sData = 64'hC; cycle();
        check("fence_ready_low", 64'(sReady), 64'd0);
        check("fence_active_set", 64'(fenceActive), 64'd1);
        sValid = 0; mReady = 1; autoBusy = 1;
        waitAck("drain_ack", 40);
        check("guard_after_busy", 64'(lastAckCyc - busyFallCyc), 64'(GUARD));
        check("drain_no_timeout", 64'(lastAckTmo), 64'd0);
        fenceReq = 0; autoBusy = 0; lat.delete(); pipeBusy = 1;
        cycle();
        cycle();

        // Guard restarts on a busy blip: 0,1,0,0.
        fenceReq = 1;
        ackBefore = ackCount;
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            pipeBusy = busyPat[i];
            cycle();
        end
        check("guard_no_early_ack", 64'(ackCount - ackBefore), 64'd0);
        check("guard_ack", 64'(fenceAck), 64'd1);

        // Request held high after the ack: one ack only, intake stays closed.
        for (int i = 0; i < 11; i++) cycle();
        check("held_single_ack", 64'(ackCount - ackBefore), 64'd1);
        check("held_ready_low", 64'(sReady), 64'd0);
        fenceReq = 0;
        cycle();
        check("release_ready", 64'(sReady), 64'd1);

        // Timeout with a beat stuck in the buffer.
        sValid = 1; sData = 64'hD00D; mReady = 0; pipeBusy = 0; cycle();
        sValid = 0; fenceReq = 1; cycle();
        waitAck("timeout_ack", 40);
        check("timeout_cycles", 64'(lastAckCyc - activeRiseCyc), 64'(TMO));
        check("timeout_flag", 64'(lastAckTmo), 64'd1);
        check("timeout_keeps_beat", mData, 64'hD00D);
        fenceReq = 0; cycle();
        check("timeout_beat_valid", 64'(mValid), 64'd1);
        mReady = 1; cycle();
        check("timeout_beat_drained", 64'(mValid), 64'd0);

        // Reset in the middle of a fence with a beat buffered.
        mReady = 0; sValid = 1; sData = 64'hE; cycle();
        sValid = 0; fenceReq = 1; cycle(); cycle(); cycle();
        ackBefore = ackCount;
        resetn = 0; fenceReq = 0; cycle();
        check("rst_m_tvalid", 64'(mValid), 64'd0);
        check("rst_active", 64'(fenceActive), 64'd0);
        check("rst_ready", 64'(sReady), 64'd0);
        resetn = 1; cycle();
        check("rst_ready_back", 64'(sReady), 64'd1);
        check("rst_no_ack", 64'(ackCount - ackBefore), 64'd0);

        // Random mix of traffic, stalls, tracker activity and fences.
        autoBusy = 1;
        for (int i = 0; i < 600; i++) begin
            sValid = 1'($urandom_range(0, 1));
            sData  = {$urandom, $urandom};
            mReady = ($urandom_range(0, 9) < 7);
            if (!fenceReq && !mFence && !mAck && !mWait && $urandom_range(0, 24) == 0)
                fenceReq = 1;
            else if (fenceReq && mWait && $urandom_range(0, 1) == 1)
                fenceReq = 0;
            cycle();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
